alu_pipe: RTL and testbench

Parametrised successor to the single-cycle add/sub ALU. Eight-operation ALU with status flags, a configurable pipeline depth, and a valid/ready handshake on both sides so downstream backpressure stalls the pipe without losing data. A caller tag travels alongside each operation so results can be matched to requests. Sits between the datapath sequencer and any consumer that may stall.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_core.sv | 34 +++
 rtl/alu_pipe.sv | 60 ++++++
 tb/tb_alu_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and status flag type shared by the ALU pipeline
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;
  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } alu_flags_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational eight-operation ALU with zero/carry/overflow flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    sh   = b[SHW-1:0];
    result = op == ALU_ADD ? sum[WIDTH-1:0]
           : op == ALU_SUB ? diff[WIDTH-1:0]
           : op == ALU_AND ? a & b
           : op == ALU_OR  ? a | b
           : op == ALU_XOR ? a ^ b
           : op == ALU_SLL ? a << sh
           : op == ALU_SRL ? a >> sh
           : {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
    flags.zero  = result == '0;
    flags.carry = op == ALU_ADD ? sum[WIDTH] : (op == ALU_SUB) && diff[WIDTH];
    flags.ovf   = op == ALU_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])
                : (op == ALU_SUB) && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: ALU followed by DEPTH valid/ready stages carrying result, tag and flags
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);
  localparam int SW = WIDTH + TAG_W + 3;
  logic [WIDTH-1:0]            core_res;
  alu_flags_t                  core_flags;
  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0][SW-1:0]    st;
  logic [DEPTH-1:0]            up_v;
  logic [DEPTH-1:0][SW-1:0]    up_d;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_in),
    .b      (b_in),
    .op     (op_in),
    .result (core_res),
    .flags  (core_flags)
  );
  // stage i is fed by stage i-1; stage 0 by the ALU output
  assign up_v = DEPTH'({v, in_valid});
  assign up_d = (DEPTH*SW)'({st, core_res, tag_in, core_flags});
  // a stage can load unless it and every stage after it are full and the consumer stalls
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign rdy[i] = out_ready || !(&v[DEPTH-1:i]);
  end
  always_ff @(posedge clk)
    if (reset) begin
      v  <= '0;
      st <= '0;
    end else
      for (int i = 0; i < DEPTH; i++)
        if (rdy[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) st[i] <= up_d[i];
        end
  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign {result_out, tag_out, flag_zero, flag_carry, flag_ovf} = st[DEPTH-1];
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  localparam int W = 32;
  localparam int D = 2;
  localparam int T = 4;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, fz, fc, fo;
  logic [W-1:0] a_in = 0, b_in = 0, result_out;
  logic [2:0] op_in = 0;
  logic [T-1:0] tag_in = 0, tag_out;
  typedef struct packed {
    logic [W-1:0] r;
    logic [T-1:0] t;
    logic z;
    logic c;
    logic o;
  } rec_t;
  rec_t exp_q[$], obs_q[$];
  int acc_q[$], pop_q[$];
  int cyc = 0, tests = 0, fails = 0;
  logic [W-1:0] ta [4] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'h80000000};
  logic [W-1:0] tb [4] = '{32'h1, 32'h1, 32'h1, 32'h21};
  logic [2:0]   top[4] = '{3'd0, 3'd1, 3'd7, 3'd6};
  logic [T-1:0] ttg[4] = '{4'd3, 4'd5, 4'd6, 4'd9};
  logic [W-1:0] tr [4] = '{32'h0, 32'h7FFFFFFF, 32'h1, 32'h40000000};
  logic [2:0]   tf [4] = '{3'b110, 3'b011, 3'b000, 3'b000};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .DEPTH(D), .TAG_W(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .op_in(op_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
    .tag_out(tag_out), .flag_zero(fz), .flag_carry(fc), .flag_ovf(fo)
  );

  function automatic rec_t model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op, logic [T-1:0] t);
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint lim = 64'sh80000000;
    longint s;
    rec_t x;
    x = '0;
    x.t = t;
    case (op)
      3'd0: begin s = sa + sb; x.r = W'(ua + ub); x.c = (ua + ub) >= 64'sh100000000; x.o = s >= lim || s < -lim; end
      3'd1: begin s = sa - sb; x.r = W'(ua - ub); x.c = ua >= ub; x.o = s >= lim || s < -lim; end
      3'd2: x.r = a & b;
      3'd3: x.r = a | b;
      3'd4: x.r = a ^ b;
      3'd5: x.r = a << (b % 32);
      3'd6: x.r = a >> (b % 32);
      default: x.r = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    x.z = x.r == 0;
    return x;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_in, b_in, op_in, tag_in));
        acc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        obs_q.push_back({result_out, tag_out, fz, fc, fo});
        pop_q.push_back(cyc);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input logic [T-1:0] t);
    a_in = a; b_in = b; op_in = op; tag_in = t; in_valid = 1;
  endtask

  task automatic clear();
    exp_q.delete(); obs_q.delete(); acc_q.delete(); pop_q.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", in_ready); end
    tests++; if (result_out !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", result_out); end
    tests++; if ({tag_out, fz, fc, fo} !== 7'h0) begin fails++; $display("FAIL reset_tagflags got %h want 0", {tag_out, fz, fc, fo}); end
  endtask

  task automatic test_directed();
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      drive(ta[k], tb[k], top[k], ttg[k]);
      tick();
      in_valid = 0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dir%0d_early got %b want 0", k, out_valid); end
      tick();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dir%0d_valid got %b want 1", k, out_valid); end
      tests++; if (result_out !== tr[k]) begin fails++; $display("FAIL dir%0d_result got %h want %h", k, result_out, tr[k]); end
      tests++; if ({fz, fc, fo} !== tf[k]) begin fails++; $display("FAIL dir%0d_flags got %b want %b", k, {fz, fc, fo}, tf[k]); end
      tests++; if (tag_out !== ttg[k]) begin fails++; $display("FAIL dir%0d_tag got %h want %h", k, tag_out, ttg[k]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    clear();
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      drive(pick(), pick(), 3'($urandom), 4'(k));
      tick();
    end
    in_valid = 0;
    for (int k = 0; k < 4; k++) tick();
    tests++; if (obs_q.size() != 8 || exp_q.size() != 8) begin fails++; $display("FAIL b2b_count got %0d want 8", obs_q.size()); end
    else
      for (int k = 0; k < 8; k++) begin
        tests++; if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL b2b_data%0d got %h want %h", k, obs_q[k], exp_q[k]); end
        tests++; if (obs_q[k].t !== 4'(k)) begin fails++; $display("FAIL b2b_order%0d got %h want %h", k, obs_q[k].t, k); end
        tests++; if (pop_q[k] != acc_q[0] + D + k) begin fails++; $display("FAIL b2b_time%0d got %0d want %0d", k, pop_q[k], acc_q[0] + D + k); end
      end
  endtask

  task automatic test_stall();
    clear();
    out_ready = 0;
    drive(pick(), pick(), 3'($urandom), 4'd8); tick();
    drive(pick(), pick(), 3'($urandom), 4'd9); tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_full got %b want 0", in_ready); end
    drive(pick(), pick(), 3'($urandom), 4'd10);
    tick(); tick();
    tests++; if (acc_q.size() != 2) begin fails++; $display("FAIL stall_accepts got %0d want 2", acc_q.size()); end
    tests++; if (out_valid !== 1'b1 || obs_q.size() != 0) begin fails++; $display("FAIL stall_hold got %b/%0d want 1/0", out_valid, obs_q.size()); end
    tests++; if ({result_out, tag_out, fz, fc, fo} !== exp_q[0]) begin fails++; $display("FAIL stall_first got %h want %h", {result_out, tag_out, fz, fc, fo}, exp_q[0]); end
    out_ready = 1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    tests++; if (acc_q.size() != 3 || pop_q.size() != 1 || acc_q[2] != pop_q[0]) begin fails++; $display("FAIL stall_swap got %0d/%0d want 3/1 same edge", acc_q.size(), pop_q.size()); end
    for (int k = 0; k < 4; k++) tick();
    tests++; if (obs_q.size() != 3) begin fails++; $display("FAIL stall_count got %0d want 3", obs_q.size()); end
    else
      for (int k = 0; k < 3; k++) begin
        tests++; if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL stall_data%0d got %h want %h", k, obs_q[k], exp_q[k]); end
      end
  endtask

  task automatic test_bubble();
    clear();
    out_ready = 0;
    drive(pick(), pick(), 3'($urandom), 4'd1); tick();
    in_valid = 0;
    for (int k = 0; k < 5; k++) tick();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL bubble_state got %b/%b want 1/1", in_ready, out_valid); end
    drive(pick(), pick(), 3'($urandom), 4'd2); tick();
    in_valid = 0;
    tests++; if (acc_q.size() != 2) begin fails++; $display("FAIL bubble_accept got %0d want 2", acc_q.size()); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bubble_full got %b want 0", in_ready); end
    tests++; if ({result_out, tag_out, fz, fc, fo} !== exp_q[0]) begin fails++; $display("FAIL bubble_head got %h want %h", {result_out, tag_out, fz, fc, fo}, exp_q[0]); end
    out_ready = 1;
    for (int k = 0; k < 4; k++) tick();
    tests++; if (obs_q.size() != 2) begin fails++; $display("FAIL bubble_count got %0d want 2", obs_q.size()); end
    else
      for (int k = 0; k < 2; k++) begin
        tests++; if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL bubble_data%0d got %h want %h", k, obs_q[k], exp_q[k]); end
      end
  endtask

  task automatic test_reset_flight();
    clear();
    out_ready = 0;
    drive(32'h12345678, 32'h1, 3'd0, 4'd4); tick();
    drive(32'hFFFF0000, 32'h00FFFF00, 3'd3, 4'd5); tick();
    in_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstfl_valid got %b want 0", out_valid); end
    tests++; if (result_out !== 32'h0 || tag_out !== 4'h0) begin fails++; $display("FAIL rstfl_data got %h/%h want 0/0", result_out, tag_out); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstfl_ready got %b want 1", in_ready); end
    out_ready = 1;
    for (int k = 0; k < 6; k++) tick();
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL rstfl_emitted got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_random();
    rec_t snap;
    logic stall;
    clear();
    for (int n = 0; n < 400; n++) begin
      a_in = pick(); b_in = pick(); op_in = 3'($urandom); tag_in = 4'($urandom);
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      #1;
      stall = out_valid && !out_ready;
      snap = {result_out, tag_out, fz, fc, fo};
      tick();
      if (stall) begin
        tests++;
        if (!out_valid || {result_out, tag_out, fz, fc, fo} !== snap) begin fails++; $display("FAIL rand_stable%0d got %h want %h", n, {result_out, tag_out, fz, fc, fo}, snap); end
      end
    end
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 8; k++) tick();
    tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    else
      for (int k = 0; k < obs_q.size(); k++) begin
        tests++; if (obs_q[k] !== exp_q[k]) begin fails++; $display("FAIL rand_data%0d got %h want %h", k, obs_q[k], exp_q[k]); end
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_bubble();
    test_reset_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
